// File: rtl/alu_mc.sv
// alu_mc: multi-cycle execute-stage ALU.
// Single-cycle logic/arithmetic/compare ops finish in one edge. Unsigned multiply
// (and unsigned divide when ALU_DIV_EN is defined) iterate for WIDTH edges. A
// start/busy/done handshake lets the datapath stall on the long operations.
// Optional feature macro: ALU_DIV_EN (restoring unsigned divider, opcode 1000).
module alu_mc #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       alucontrol,
    input  logic [WIDTH-1:0] srca,
    input  logic [WIDTH-1:0] srcb,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic             zero
);

    localparam int CNTW = $clog2(WIDTH) + 1;

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SLTU = 4'b0011;
    localparam logic [3:0] OP_XOR  = 4'b0100;
    localparam logic [3:0] OP_MULU = 4'b0101;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0111;
`ifdef ALU_DIV_EN
    localparam logic [3:0] OP_DIVU = 4'b1000;
`endif

    typedef enum logic {
        IDLE,
        ITER
    } state_t;

    state_t state, state_n;

    logic [CNTW-1:0]  count;
    logic [WIDTH-1:0] acc_hi;
    logic [WIDTH-1:0] acc_lo;
    logic [WIDTH-1:0] opb;
    logic             done_q;
    logic [WIDTH-1:0] result_q;
    logic [WIDTH-1:0] result_hi_q;

    logic             is_mul_op;
    logic             is_div_op;
    logic             start_iter;
    logic             last_step;
    logic [WIDTH-1:0] single_lo;
    logic [WIDTH-1:0] single_hi;

    logic [WIDTH:0]   mul_sum;
    logic [WIDTH-1:0] mul_hi_n;
    logic [WIDTH-1:0] mul_lo_n;
    logic [WIDTH-1:0] step_hi;
    logic [WIDTH-1:0] step_lo;

`ifdef ALU_DIV_EN
    logic             is_div;
    logic [WIDTH:0]   div_shift;
    logic             div_fits;
    logic [WIDTH-1:0] div_diff;
    logic [WIDTH-1:0] div_rem_n;
    logic [WIDTH-1:0] div_quo_n;
`endif

    assign busy      = (state == ITER);
    assign done      = done_q;
    assign result    = result_q;
    assign result_hi = result_hi_q;
    assign zero      = (result_q == '0);

    // Decode: which ops need the iterative path, and is this the final iteration.
    always_comb begin
        is_mul_op = (alucontrol == OP_MUL_CHECK());
`ifdef ALU_DIV_EN
        is_div_op = (alucontrol == OP_DIVU);
`else
        is_div_op = 1'b0;
`endif
        start_iter = start && (is_mul_op || (is_div_op && (srcb != '0)));
        last_step  = (state == ITER) && (count == CNTW'(1));
    end

    function automatic logic [3:0] OP_MUL_CHECK();
        return OP_MULU;
    endfunction

    // Single-cycle results; a divide reaching here always has a zero divisor.
    always_comb begin
        single_lo = '0;
        single_hi = '0;
        case (alucontrol)
            OP_AND:  single_lo = srca & srcb;
            OP_OR:   single_lo = srca | srcb;
            OP_XOR:  single_lo = srca ^ srcb;
            OP_ADD:  single_lo = srca + srcb;
            OP_SUB:  single_lo = srca - srcb;
            OP_SLT:  single_lo = {{(WIDTH-1){1'b0}}, ($signed(srca) < $signed(srcb))};
            OP_SLTU: single_lo = {{(WIDTH-1){1'b0}}, (srca < srcb)};
`ifdef ALU_DIV_EN
            OP_DIVU: begin
                single_lo = '1;
                single_hi = srca;
            end
`endif
            default: begin
                single_lo = '0;
                single_hi = '0;
            end
        endcase
    end

    // One iteration step: shift-add multiply and (optionally) restoring divide.
    always_comb begin
        mul_sum  = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opb} : {(WIDTH+1){1'b0}});
        mul_hi_n = mul_sum[WIDTH:1];
        mul_lo_n = {mul_sum[0], acc_lo[WIDTH-1:1]};
`ifdef ALU_DIV_EN
        div_shift = {acc_hi, acc_lo[WIDTH-1]};
        div_fits  = (div_shift >= {1'b0, opb});
        div_diff  = div_shift[WIDTH-1:0] - opb;
        div_rem_n = div_fits ? div_diff : div_shift[WIDTH-1:0];
        div_quo_n = {acc_lo[WIDTH-2:0], div_fits};
        step_hi   = is_div ? div_rem_n : mul_hi_n;
        step_lo   = is_div ? div_quo_n : mul_lo_n;
`else
        step_hi   = mul_hi_n;
        step_lo   = mul_lo_n;
`endif
    end

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // FSM next state: enter ITER for accepted long ops, leave on the final step.
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (start_iter) state_n = ITER;
            ITER:    if (last_step)  state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Datapath: operand capture, iteration registers, registered results and done pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count       <= '0;
            acc_hi      <= '0;
            acc_lo      <= '0;
            opb         <= '0;
            done_q      <= 1'b0;
            result_q    <= '0;
            result_hi_q <= '0;
`ifdef ALU_DIV_EN
            is_div      <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            if (state == IDLE) begin
                if (start_iter) begin
                    acc_hi <= '0;
                    acc_lo <= srca;
                    opb    <= srcb;
                    count  <= CNTW'(WIDTH);
`ifdef ALU_DIV_EN
                    is_div <= is_div_op;
`endif
                end else if (start) begin
                    result_q    <= single_lo;
                    result_hi_q <= single_hi;
                    done_q      <= 1'b1;
                end
            end else begin
                acc_hi <= step_hi;
                acc_lo <= step_lo;
                count  <= count - CNTW'(1);
                if (last_step) begin
                    result_q    <= step_lo;
                    result_hi_q <= step_hi;
                    done_q      <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_mc.sv
// tb_alu_mc: directed-vector bench for alu_mc with a scoreboard queue.
// Stimulus pushes expected results when it issues an op; a monitor pops and
// compares whenever the DUT pulses done.
module tb_alu_mc;

    localparam int WIDTH = 32;

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SLTU = 4'b0011;
    localparam logic [3:0] OP_XOR  = 4'b0100;
    localparam logic [3:0] OP_MULU = 4'b0101;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [3:0] OP_DIVU = 4'b1000;
    localparam logic [3:0] OP_ILL  = 4'b1111;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic [3:0]       alucontrol;
    logic [WIDTH-1:0] srca;
    logic [WIDTH-1:0] srcb;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] result_hi;
    logic             zero;

    typedef struct {
        string            tag;
        logic [WIDTH-1:0] res;
        logic [WIDTH-1:0] hi;
        logic             zero;
    } exp_t;

    exp_t sb[$];
    int   compared   = 0;
    int   mismatched = 0;

    alu_mc #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .alucontrol (alucontrol),
        .srca       (srca),
        .srcb       (srcb),
        .busy       (busy),
        .done       (done),
        .result     (result),
        .result_hi  (result_hi),
        .zero       (zero)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, actual, expected);
        end
    endtask

    // Issue one op; on return we sit 1 time unit after the accepting edge.
    task automatic applyStimulus(input logic [3:0] op, input logic [WIDTH-1:0] a,
                                 input logic [WIDTH-1:0] b, input string tag,
                                 input logic [WIDTH-1:0] exp_res, input logic [WIDTH-1:0] exp_hi);
        exp_t e;
        e.tag  = tag;
        e.res  = exp_res;
        e.hi   = exp_hi;
        e.zero = (exp_res == '0);
        sb.push_back(e);
        start      = 1'b1;
        alucontrol = op;
        srca       = a;
        srcb       = b;
        @(posedge clk);
        #1;
        start = 1'b0;
        srca  = $urandom;
        srcb  = $urandom;
    endtask

    // Count edges after acceptance until done, with busy sampling and optional ignored start.
    task automatic waitDone(input string tag, input int exp_edges, input int exp_busy, input bit inject);
        int edges      = 0;
        int busy_count = 0;
        while (done !== 1'b1 && edges < 100) begin
            if (busy === 1'b1) busy_count++;
            if (inject && edges == 4) begin
                start      = 1'b1;
                alucontrol = OP_ADD;
                srca       = 32'd1;
                srcb       = 32'd1;
            end
            @(posedge clk);
            #1;
            if (inject) start = 1'b0;
            edges++;
        end
        checkOutput({tag, "_latency"}, 64'(edges), 64'(exp_edges));
        checkOutput({tag, "_busy_cycles"}, 64'(busy_count), 64'(exp_busy));
        checkOutput({tag, "_busy_at_done"}, {63'd0, busy}, 64'd0);
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        exp_t e;
        if (reset === 1'b0 && done === 1'b1) begin
            if (sb.size() == 0) begin
                checkOutput("unexpected_done", {63'd0, done}, 64'd0);
            end else begin
                e = sb.pop_front();
                checkOutput({e.tag, "_result"}, {32'd0, result}, {32'd0, e.res});
                checkOutput({e.tag, "_result_hi"}, {32'd0, result_hi}, {32'd0, e.hi});
                checkOutput({e.tag, "_zero"}, {63'd0, zero}, {63'd0, e.zero});
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, want normal finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed stimulus sequence.
    initial begin
        reset      = 1'b1;
        start      = 1'b0;
        alucontrol = 4'd0;
        srca       = '0;
        srcb       = '0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_busy", {63'd0, busy}, 64'd0);
        checkOutput("reset_done", {63'd0, done}, 64'd0);
        checkOutput("reset_result", {32'd0, result}, 64'd0);
        checkOutput("reset_result_hi", {32'd0, result_hi}, 64'd0);
        checkOutput("reset_zero", {63'd0, zero}, 64'd1);
        #2 reset = 1'b0;
        @(posedge clk);
        #1;

        applyStimulus(OP_ADD, 32'h7FFF_FFFF, 32'h0000_0001, "add_ovf", 32'h8000_0000, 32'h0);
        waitDone("add_ovf", 0, 0, 1'b0);
        applyStimulus(OP_SLT, 32'hFFFF_FFFF, 32'h0000_0001, "slt", 32'h1, 32'h0);
        waitDone("slt", 0, 0, 1'b0);
        applyStimulus(OP_SLTU, 32'hFFFF_FFFF, 32'h0000_0001, "sltu", 32'h0, 32'h0);
        waitDone("sltu", 0, 0, 1'b0);
        applyStimulus(OP_SUB, 32'd5, 32'd5, "sub_zero", 32'h0, 32'h0);
        waitDone("sub_zero", 0, 0, 1'b0);
        applyStimulus(OP_ILL, 32'h1234_5678, 32'h9ABC_DEF0, "illegal", 32'h0, 32'h0);
        waitDone("illegal", 0, 0, 1'b0);

        applyStimulus(OP_MULU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulu_max", 32'h0000_0001, 32'hFFFF_FFFE);
        waitDone("mulu_max", 32, 32, 1'b1);
        applyStimulus(OP_MULU, 32'h1234_5678, 32'h0000_0010, "mulu_small", 32'h2345_6780, 32'h0000_0001);
        waitDone("mulu_small", 32, 32, 1'b0);

`ifdef ALU_DIV_EN
        applyStimulus(OP_DIVU, 32'd100, 32'd7, "divu", 32'd14, 32'd2);
        waitDone("divu", 32, 32, 1'b0);
        applyStimulus(OP_DIVU, 32'd9, 32'd0, "divu_by0", 32'hFFFF_FFFF, 32'd9);
        waitDone("divu_by0", 0, 0, 1'b0);
`else
        applyStimulus(OP_DIVU, 32'd100, 32'd7, "divu_off", 32'd0, 32'd0);
        waitDone("divu_off", 0, 0, 1'b0);
        applyStimulus(OP_DIVU, 32'd9, 32'd0, "divu_by0_off", 32'd0, 32'd0);
        waitDone("divu_by0_off", 0, 0, 1'b0);
`endif

        applyStimulus(OP_MULU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulu_abort", 32'h0, 32'h0);
        repeat (10) begin
            @(posedge clk);
            #1;
        end
        reset = 1'b1;
        #1;
        void'(sb.pop_back());
        checkOutput("abort_busy", {63'd0, busy}, 64'd0);
        checkOutput("abort_done", {63'd0, done}, 64'd0);
        checkOutput("abort_result", {32'd0, result}, 64'd0);
        #2 reset = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("abort_no_done", {63'd0, done}, 64'd0);
        applyStimulus(OP_ADD, 32'd2, 32'd3, "add_after_abort", 32'd5, 32'd0);
        waitDone("add_after_abort", 0, 0, 1'b0);

        applyStimulus(OP_AND, 32'hF0F0_1234, 32'h0FF0_00FF, "b2b_and", 32'h00F0_0034, 32'h0);
        checkOutput("b2b_and_done", {63'd0, done}, 64'd1);
        applyStimulus(OP_OR, 32'hF0F0_1234, 32'h0FF0_00FF, "b2b_or", 32'hFFF0_12FF, 32'h0);
        checkOutput("b2b_or_done", {63'd0, done}, 64'd1);
        applyStimulus(OP_XOR, 32'hF0F0_1234, 32'h0FF0_00FF, "b2b_xor", 32'hFF00_12CB, 32'h0);
        checkOutput("b2b_xor_done", {63'd0, done}, 64'd1);
        applyStimulus(OP_ADD, 32'hF0F0_1234, 32'h0FF0_00FF, "b2b_add", 32'h00E0_1333, 32'h0);
        checkOutput("b2b_add_done", {63'd0, done}, 64'd1);
        @(posedge clk);
        #1;
        checkOutput("b2b_done_drops", {63'd0, done}, 64'd0);
        checkOutput("hold_result", {32'd0, result}, {32'd0, 32'h00E0_1333});

        repeat (3) @(posedge clk);
        #1;
        checkOutput("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
